// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch front end.
//   INSTR_BYTES      - byte stride between consecutive instructions
//   HALT_INSTR       - encoding that stops fetch when FETCH_HALT_EN is defined
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   fetch_entry_t    - {pc, instr} pair held in the output buffer
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W     = 10;
  localparam int unsigned FETCH_INSTR_W    = 32;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam logic [FETCH_INSTR_W-1:0] HALT_INSTR = 32'hFC00_0000;

  // Field widths follow the package widths; the top level's ADDR_W/INSTR_W
  // are expected to match them.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of fetch_entry_t between memory capture and decode.
//   clk, reset   - clock, asynchronous active-high reset (clears control only)
//   push         - write push_entry at the tail
//   push_entry   - entry to write
//   pop          - drop the head entry
//   flush        - discard all entries (wins over push and pop)
//   count        - number of valid entries (0..2)
//   head         - oldest entry; meaningful only while count != 0
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch front end ahead of a registered,
// byte-addressed, big-endian instruction memory.
//   clk, reset      - clock, asynchronous active-high reset
//   imem_addr       - byte address to memory (registered fetch_pc)
//   imem_instr      - memory data for the address sampled at the previous edge
//   redirect_valid  - branch/jump taken; redirect_pc is the target (low 2 bits ignored)
//   out_valid/ready - valid/ready handshake to decode
//   out_instr       - fetched instruction
//   out_pc          - address of out_instr; out_pc_plus4 = out_pc + 4 (wraps)
//   halted          - fetch stopped on HALT_INSTR
// Optional feature: define FETCH_HALT_EN to stop issuing after a HALT_INSTR is
// captured; otherwise halted is tied to 0 and HALT_INSTR is an ordinary word.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4,
  output logic               halted
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic              pop;
  logic              issue_credit;
  logic              halt_block;
  logic              issue;
  logic [1:0]        buf_count;
  fetch_entry_t      buf_head;
  fetch_entry_t      push_entry;

  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Entries buffered plus the one in flight must leave room for the word
  // this issue will return; a same-cycle pop frees one slot.
  assign issue_credit = (int'(buf_count) + int'(inflight_q)) < (int'(BUF_DEPTH) + int'(pop));

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  logic halt_capture;

  // Issue is blocked from the very edge that captures HALT, so the PC after
  // it is never requested.
  assign halt_capture = inflight_q && (imem_instr == HALT_INSTR);
  assign halt_block   = halted_q | halt_capture;
  assign halted_d     = redirect_valid ? 1'b0 : (halted_q | halt_capture);
  assign halted       = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halt_block = 1'b0;
  assign halted     = 1'b0;
`endif

  assign issue = !redirect_valid && !halt_block && issue_credit;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= ADDR_W'(RESET_PC);
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  assign imem_addr = fetch_pc_q;

  // A redirect squashes the returning word and flushes the buffer; the pop
  // in that same cycle still completes on the decode side.
  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_instr;

  fetch_skid_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q & ~redirect_valid),
    .push_entry (push_entry),
    .pop        (pop & ~redirect_valid),
    .flush      (redirect_valid),
    .count      (buf_count),
    .head       (buf_head)
  );

  // Outputs read zero whenever nothing is valid, including right after reset.
  assign out_instr    = out_valid ? buf_head.instr : '0;
  assign out_pc       = out_valid ? buf_head.pc : '0;
  assign out_pc_plus4 = out_valid ? (buf_head.pc + ADDR_W'(INSTR_BYTES)) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic [9:0]  imem_addr;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [9:0]  out_pc, out_pc_plus4;
  logic        halted;

  // Second DUT (RESET_PC = 0x3F8), always ready, never redirected
  logic [9:0]  imem_addr_b;
  logic [31:0] imem_instr_b = '0;
  logic        out_valid_b;
  logic [31:0] out_instr_b;
  logic [9:0]  out_pc_b, out_pc_plus4_b;
  logic        halted_b;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .halted(halted)
  );

  instr_fetch_unit #(.RESET_PC(10'h3F8)) dut_b (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
    .redirect_valid(1'b0), .redirect_pc(10'h000),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_instr(out_instr_b),
    .out_pc(out_pc_b), .out_pc_plus4(out_pc_plus4_b), .halted(halted_b)
  );

  // Byte memories, big-endian word assembly, registered read
  logic [7:0] mem   [1024];
  logic [7:0] mem_b [1024];

  function automatic logic [31:0] word_a(input logic [9:0] a);
    logic [9:0] a1, a2, a3;
    a1 = a + 10'd1; a2 = a + 10'd2; a3 = a + 10'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  function automatic logic [31:0] word_b(input logic [9:0] a);
    logic [9:0] a1, a2, a3;
    a1 = a + 10'd1; a2 = a + 10'd2; a3 = a + 10'd3;
    return {mem_b[a], mem_b[a1], mem_b[a2], mem_b[a3]};
  endfunction

  always @(posedge clk) begin
    imem_instr   <= word_a(imem_addr);
    imem_instr_b <= word_b(imem_addr_b);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the delivered stream is consecutive PCs from the last
  // restart point; output is valid from the 2nd edge after reset release or
  // redirect, and never drops until a redirect (or a delivered HALT).
  int         since = 0, since_b = 0;
  logic [9:0] exp_pc = 10'h000, exp_pc_b = 10'h3F8;
  bit         halt_done = 1'b0;

  always @(negedge clk) begin
    logic       ev, ev_b;
    logic [9:0] p4;
    if (reset) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_plus4", out_pc_plus4, 0);
      chk("rst_halted", halted, 0);
      chk("rst_valid_b", out_valid_b, 0);
      since = 0; since_b = 0; halt_done = 1'b0;
      exp_pc = 10'h000; exp_pc_b = 10'h3F8;
    end else begin
      ev = (since >= 2) && !halt_done;
      chk("m_valid", out_valid, ev);
      if (ev) begin
        p4 = exp_pc + 10'd4;
        chk("m_pc", out_pc, exp_pc);
        chk("m_instr", out_instr, word_a(exp_pc));
        chk("m_plus4", out_pc_plus4, p4);
      end
`ifdef FETCH_HALT_EN
      if (halt_done) chk("m_halted", halted, 1);
      else if (since == 0) chk("m_halted", halted, 0);
`else
      chk("m_halted", halted, 0);
`endif
      if (ev && out_ready) begin
`ifdef FETCH_HALT_EN
        if (word_a(exp_pc) == HALT_INSTR) halt_done = 1'b1;
`endif
        exp_pc = exp_pc + 10'd4;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & 10'h3FC;
        since = 0;
        halt_done = 1'b0;
      end else if (since < 2) begin
        since++;
      end

      ev_b = (since_b >= 2);
      chk("m_valid_b", out_valid_b, ev_b);
      if (ev_b) begin
        p4 = exp_pc_b + 10'd4;
        chk("m_pc_b", out_pc_b, exp_pc_b);
        chk("m_instr_b", out_instr_b, word_b(exp_pc_b));
        chk("m_plus4_b", out_pc_plus4_b, p4);
        exp_pc_b = exp_pc_b + 10'd4;
      end
      if (since_b < 2) since_b++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i += 4)
      if ({mem[i], mem[i+1], mem[i+2], mem[i+3]} == HALT_INSTR) mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) mem_b[i] = mem[i];
    {mem[0], mem[1], mem[2], mem[3]}    = 32'h1122_3344;
    {mem[4], mem[5], mem[6], mem[7]}    = 32'h5566_7788;
    {mem[8], mem[9], mem[10], mem[11]}  = 32'h99AA_BBCC;
    {mem[12], mem[13], mem[14], mem[15]} = 32'hDDEE_F001;

    // Reset release, ready held high: first valid after 2nd edge
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("lat_not_yet", out_valid, 0);
    tick(1);
    chk("first_valid", out_valid, 1);
    chk("first_pc", out_pc, 32'h000);
    chk("first_instr", out_instr, 32'h1122_3344);
    chk("wrap_pc0", out_pc_b, 32'h3F8);
    tick(1);
    chk("seq_pc1", out_pc, 32'h004);
    chk("seq_instr1", out_instr, 32'h5566_7788);
    chk("wrap_pc1", out_pc_b, 32'h3FC);
    chk("wrap_plus4", out_pc_plus4_b, 32'h000);
    tick(1);
    chk("seq_pc2", out_pc, 32'h008);
    chk("seq_instr2", out_instr, 32'h99AA_BBCC);
    chk("wrap_pc2", out_pc_b, 32'h000);
    tick(1);
    chk("seq_pc3", out_pc, 32'h00C);
    chk("seq_instr3", out_instr, 32'hDDEE_F001);

    // Backpressure: fetch stops with 2 buffered, nothing skipped on resume
    reset = 1'b1;
    tick(1);
    out_ready = 1'b0;
    reset = 1'b0;
    tick(2);
    chk("stall_first", out_pc, 32'h000);
    tick(5);
    chk("stall_hold_pc", out_pc, 32'h000);
    chk("stall_addr", imem_addr, 32'h008);
    out_ready = 1'b1;
    tick(1);
    chk("resume_pc1", out_pc, 32'h004);
    tick(1);
    chk("resume_pc2", out_pc, 32'h008);

    // Redirect with a full buffer
    out_ready = 1'b0;
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc = 10'h103;
    tick(1);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("redir_squash", out_valid, 0);
    tick(1);
    chk("redir_gap", out_valid, 0);
    tick(1);
    chk("redir_valid", out_valid, 1);
    chk("redir_pc0", out_pc, 32'h100);
    tick(1);
    chk("redir_pc1", out_pc, 32'h104);

    // Asynchronous reset between edges
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_halted", halted, 0);
    chk("async_pc", out_pc, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2);
    chk("restart_valid", out_valid, 1);
    chk("restart_pc", out_pc, 32'h000);

    // HALT word at 0x008
    reset = 1'b1;
    {mem[8], mem[9], mem[10], mem[11]} = HALT_INSTR;
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("halt_pc0", out_pc, 32'h000);
    tick(1);
    chk("halt_pc1", out_pc, 32'h004);
    tick(1);
    chk("halt_pc2", out_pc, 32'h008);
    chk("halt_word", out_instr, 32'hFC00_0000);
    tick(1);
`ifdef FETCH_HALT_EN
    chk("halt_drained", out_valid, 0);
    chk("halt_flag", halted, 1);
    chk("halt_addr", imem_addr, 32'h00C);
    tick(3);
    chk("halt_addr_frozen", imem_addr, 32'h00C);
    redirect_valid = 1'b1;
    redirect_pc = 10'h020;
    tick(1);
    redirect_valid = 1'b0;
    chk("halt_cleared", halted, 0);
    tick(2);
    chk("halt_resume", out_pc, 32'h020);
`else
    chk("nohalt_pc3", out_pc, 32'h00C);
    chk("nohalt_instr3", out_instr, 32'hDDEE_F001);
    chk("nohalt_flag", halted, 0);
`endif

    // Randomized traffic against the model
    reset = 1'b1;
    {mem[8], mem[9], mem[10], mem[11]} = 32'h99AA_BBCC;
    tick(1);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = (($urandom % 4) != 0);
      redirect_valid = (($urandom % 20) == 0);
      redirect_pc = 10'($urandom);
      tick(1);
    end
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
